// File: rtl/alu_issue_sched_pkg.sv
// Shared definitions for the ALU issue scheduler: datapath width, privilege
// encoding, scheduler FSM states and the issue payload record.
package alu_issue_sched_pkg;

  localparam int XLEN   = 64;
  localparam int ITAG_W = 8;

  localparam logic [1:0] PRV_MACHINE = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACK   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [1:0]        opinfo;
    logic [ITAG_W-1:0] itag;
    logic [1:0]        priv;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   ds1;
    logic [XLEN-1:0]   ds2;
  } issue_pay_t;

  // Cleared slot contents: all zero except machine privilege.
  function automatic issue_pay_t reset_payload();
    issue_pay_t p;
    p      = '0;
    p.priv = PRV_MACHINE;
    return p;
  endfunction

endpackage

// File: rtl/alu_issue_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the other port only
// when the caller reports that the grant was actually taken.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (|grant_o)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Single-slot ALU issue stage: arbitrates two requesters into one registered
// issue slot, with flush and a fence drain/acknowledge handshake.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
(
  input  logic            ALUSCHi_CLK,
  input  logic            ALUSCHi_RST,
  input  logic            ALUSCHi_Flush,
  input  logic            ALUSCHi_P0_valid,
  input  logic [7:0]      ALUSCHi_P0_Opcode,
  input  logic [1:0]      ALUSCHi_P0_OpInfo,
  input  logic [7:0]      ALUSCHi_P0_itag,
  input  logic [1:0]      ALUSCHi_P0_priv,
  input  logic [XLEN-1:0] ALUSCHi_P0_PC,
  input  logic [XLEN-1:0] ALUSCHi_P0_ds1,
  input  logic [XLEN-1:0] ALUSCHi_P0_ds2,
  output logic            ALUSCHo_P0_ready,
  input  logic            ALUSCHi_P1_valid,
  input  logic [7:0]      ALUSCHi_P1_Opcode,
  input  logic [1:0]      ALUSCHi_P1_OpInfo,
  input  logic [7:0]      ALUSCHi_P1_itag,
  input  logic [1:0]      ALUSCHi_P1_priv,
  input  logic [XLEN-1:0] ALUSCHi_P1_PC,
  input  logic [XLEN-1:0] ALUSCHi_P1_ds1,
  input  logic [XLEN-1:0] ALUSCHi_P1_ds2,
  output logic            ALUSCHo_P1_ready,
  output logic            ALUSCHo_valid,
  output logic [7:0]      ALUSCHo_Opcode,
  output logic [1:0]      ALUSCHo_OpInfo,
  output logic [7:0]      ALUSCHo_itag,
  output logic [1:0]      ALUSCHo_priv,
  output logic [XLEN-1:0] ALUSCHo_PC,
  output logic [XLEN-1:0] ALUSCHo_ds1,
  output logic [XLEN-1:0] ALUSCHo_ds2,
  input  logic            ALUSCHi_ready,
  input  logic            ALUSCHi_FENCE_req,
  output logic            ALUSCHo_FENCE_ack
);

  sched_state_e state_q, state_d;
  logic         slot_valid_q, slot_valid_d;
  issue_pay_t   slot_q, slot_d;
  issue_pay_t   p0_pay, p1_pay;
  logic         ld_en, grant_ok;
  logic [1:0]   req_valid, grant, accept;

  assign p0_pay = '{opcode: ALUSCHi_P0_Opcode, opinfo: ALUSCHi_P0_OpInfo, itag: ALUSCHi_P0_itag,
                    priv: ALUSCHi_P0_priv, pc: ALUSCHi_P0_PC, ds1: ALUSCHi_P0_ds1, ds2: ALUSCHi_P0_ds2};
  assign p1_pay = '{opcode: ALUSCHi_P1_Opcode, opinfo: ALUSCHi_P1_OpInfo, itag: ALUSCHi_P1_itag,
                    priv: ALUSCHi_P1_priv, pc: ALUSCHi_P1_PC, ds1: ALUSCHi_P1_ds1, ds2: ALUSCHi_P1_ds2};

  // A raised fence blocks new grants in the very cycle it appears.
  assign ld_en     = !slot_valid_q | ALUSCHi_ready;
  assign grant_ok  = ld_en & (state_q == ST_RUN) & !ALUSCHi_FENCE_req
                   & !ALUSCHi_Flush & !ALUSCHi_RST;
  assign req_valid = {ALUSCHi_P1_valid, ALUSCHi_P0_valid};

  rr_arb2 u_arb (
    .clk_i     (ALUSCHi_CLK),
    .rst_i     (ALUSCHi_RST),
    .valid_i   (req_valid),
    .advance_i (grant_ok),
    .grant_o   (grant)
  );

  assign accept           = grant & {2{grant_ok}};
  assign ALUSCHo_P0_ready = accept[0];
  assign ALUSCHo_P1_ready = accept[1];

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    if (ALUSCHi_Flush) begin
      slot_valid_d = 1'b0;
    end else if (ld_en) begin
      slot_valid_d = |accept;
      if (accept[0]) begin
        slot_d = p0_pay;
      end else if (accept[1]) begin
        slot_d = p1_pay;
      end
    end
  end

  always_ff @(posedge ALUSCHi_CLK) begin
    if (ALUSCHi_RST) begin
      slot_valid_q <= 1'b0;
      slot_q       <= reset_payload();
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
    end
  end

  always_ff @(posedge ALUSCHi_CLK) begin
    if (ALUSCHi_RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush freezes RUN/DRAIN; the ACK pulse is always exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (ALUSCHi_FENCE_req && !ALUSCHi_Flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!slot_valid_q && !ALUSCHi_Flush) state_d = ST_ACK;
      ST_ACK:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ALUSCHo_FENCE_ack = (state_q == ST_ACK);
  end

  assign ALUSCHo_valid  = slot_valid_q;
  assign ALUSCHo_Opcode = slot_q.opcode;
  assign ALUSCHo_OpInfo = slot_q.opinfo;
  assign ALUSCHo_itag   = slot_q.itag;
  assign ALUSCHo_priv   = slot_q.priv;
  assign ALUSCHo_PC     = slot_q.pc;
  assign ALUSCHo_ds1    = slot_q.ds1;
  assign ALUSCHo_ds2    = slot_q.ds2;

endmodule

// File: doc/alu_issue_sched.md
ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 SHALL have no parameters; XLEN (64) comes from the shared config header; the ITAG width is fixed at 8.
REQ-002 SHALL have port ALUSCHi_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port ALUSCHi_RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ALUSCHi_Flush, input, 1 bit: pipeline flush.
REQ-005 SHALL have ports ALUSCHi_Pn_valid, input, 1 bit: request valid from requester n (n = 0, 1).
REQ-006 SHALL have ports ALUSCHi_Pn_Opcode / OpInfo / itag / priv, inputs, 8 / 2 / 8 / 2 bits: request payload.
REQ-007 SHALL have ports ALUSCHi_Pn_PC / ds1 / ds2, inputs, XLEN bits each: request payload.
REQ-008 SHALL have ports ALUSCHo_Pn_ready, output, 1 bit: request n accepted this cycle.
REQ-009 SHALL have port ALUSCHo_valid, output, 1 bit: issue slot valid toward the ALU.
REQ-010 SHALL have ports ALUSCHo_Opcode / OpInfo / itag / priv / PC / ds1 / ds2, outputs, with the same widths as inputs: issued payload.
REQ-011 SHALL have port ALUSCHi_ready, input, 1 bit: the ALU accepts the issue slot.
REQ-012 SHALL have ports ALUSCHi_FENCE_req, input, 1 bit, and ALUSCHo_FENCE_ack, output, 1 bit: the drain handshake.

Function
REQ-013 SHALL hold one registered issue slot; ld_en = !ALUSCHo_valid | ALUSCHi_ready.
REQ-014 SHALL assert ALUSCHo_Pn_ready combinationally iff ld_en, state is RUN, Flush is 0, and n is the arbitration winner.
REQ-015 SHALL arbitrate as follows: a sole valid requester wins; when both are valid, the round-robin pointer wins.
REQ-016 SHALL, after each accepted grant, set the pointer to the other port; it SHALL NOT change the pointer otherwise.
REQ-017 SHALL, on acceptance in cycle N, present the payload with ALUSCHo_valid=1 in cycle N+1: latency 1, throughput 1 per cycle.
REQ-018 SHALL clear ALUSCHo_valid when ld_en=1 and no request is accepted.
REQ-019 SHALL hold the slot payload and valid stable while ALUSCHo_valid & !ALUSCHi_ready.
REQ-020 SHALL give Flush=1 priority over everything: the slot is invalidated next cycle, no ready is asserted, and the pointer and FSM state are unchanged.
REQ-021 SHALL implement FSM states RUN, DRAIN and ACK.
REQ-022 SHALL move from RUN to DRAIN when FENCE_req=1; no grants are made in DRAIN or ACK.
REQ-023 SHALL move from DRAIN to ACK once ALUSCHo_valid=0, whether the slot emptied through ALU acceptance or through Flush.
REQ-024 SHALL, in ACK, drive FENCE_ack=1 for exactly one cycle and then return to RUN unconditionally.
REQ-025 SHALL, if FENCE_req is still 1 in RUN, re-enter DRAIN; this is legal, and the requester drops the request on ack.
REQ-026 SHALL, when FENCE_req rises while a request is valid, block that request from that cycle on; the in-flight slot completes normally.
REQ-027 SHALL leave payload outputs don't-care-stable when ALUSCHo_valid=0 (last value held).

Reset
REQ-028 SHALL, while ALUSCHi_RST=1 at a clock edge, set ALUSCHo_valid=0, payload=0, ALUSCHo_priv=`Machine (2'b11), FENCE_ack=0, state=RUN and pointer=0.
REQ-029 SHALL give reset priority over Flush, FENCE and handshakes; mid-operation reset drops the slot without an ack.
REQ-030 SHALL keep ALUSCHo_Pn_ready=0 during reset cycles.

Structure
REQ-031 SHALL place the FSM state encodings and `Machine in the shared PRV564Define header; XLEN comes from PRV564Config.
REQ-032 SHALL implement arbitration in one sub-module, rr_arb2 (valid[1:0], ptr, advance -> one-hot grant), with the slot register and FSM in the top.
REQ-033 SHALL be sized at 120-400 lines of RTL; no memories.

Verification
REQ-034 SHALL verify: P0 only valid, ALUSCHi_ready=1, itag=8'h11 -> P0_ready same cycle; ALUSCHo_valid=1, itag=8'h11 next cycle.
REQ-035 SHALL verify: P0 and P1 both valid for 4 cycles, ALU always ready -> grants P0,P1,P0,P1; ALUSCHo_itag alternates.
REQ-036 SHALL verify: slot valid, ALUSCHi_ready=0 for 3 cycles -> both Pn_ready=0 and the payload is unchanged; the ALU accepts on cycle 4.
REQ-037 SHALL verify: Flush=1 with the slot valid and P1 valid -> P1_ready=0; ALUSCHo_valid=0 next cycle; the pointer is unchanged.
REQ-038 SHALL verify: FENCE_req=1 with the slot valid and ALU stalled 2 cycles -> no grants; FENCE_ack pulses 1 cycle after the slot empties; grants resume next cycle.
REQ-039 SHALL verify: RST=1 mid-DRAIN with the slot valid -> next cycle valid=0, priv=2'b11, state RUN, no FENCE_ack.
